// File: rtl/decode_pkg.sv
// Shared constants and types for the ID-stage decoder.
// The DECODE_KEYWORD_EN macro (see decode_control.sv) uses dp_mnemonic() below.
package decode_pkg;

  // ALU opcodes (data-processing field [24:21])
  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  // Addressing-mode encodings
  localparam logic [1:0] AM_DP_IMM = 2'b00;
  localparam logic [1:0] AM_DP_REG = 2'b01;
  localparam logic [1:0] AM_LS_IMM = 2'b10;
  localparam logic [1:0] AM_LS_REG = 2'b11;

  // Condition codes
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  typedef struct packed {
    logic [3:0] opcode;
    logic [1:0] am;
    logic       s_enable;
    logic       load_instr;
    logic       rf_enable;
    logic       size_enable;
    logic       rw_enable;
    logic       enable_signal;
    logic       bl_instr;
    logic       b_instr;
  } ctrl_t;

  function automatic logic [47:0] dp_mnemonic(input logic [3:0] op);
    logic [47:0] s;
    case (op)
      OP_AND:  s = "AND   ";
      OP_EOR:  s = "EOR   ";
      OP_SUB:  s = "SUB   ";
      OP_RSB:  s = "RSB   ";
      OP_ADD:  s = "ADD   ";
      OP_ADC:  s = "ADC   ";
      OP_SBC:  s = "SBC   ";
      OP_RSC:  s = "RSC   ";
      OP_TST:  s = "TST   ";
      OP_TEQ:  s = "TEQ   ";
      OP_CMP:  s = "CMP   ";
      OP_CMN:  s = "CMN   ";
      OP_ORR:  s = "ORR   ";
      OP_MOV:  s = "MOV   ";
      OP_BIC:  s = "BIC   ";
      default: s = "MVN   ";
    endcase
    return s;
  endfunction

endpackage

// File: rtl/decode_cond_eval.sv
// ARM condition-code evaluator: flags are {N,Z,C,V}.
module cond_eval
  import decode_pkg::*;
(
  input  logic [3:0] cond_code,
  input  logic [3:0] flags,
  output logic       cond_true
);

  logic w_n, w_z, w_c, w_v;
  assign {w_n, w_z, w_c, w_v} = flags;

  always_comb begin
    cond_true = 1'b0;
    case (cond_code)
      COND_EQ: cond_true = w_z;
      COND_NE: cond_true = ~w_z;
      COND_CS: cond_true = w_c;
      COND_CC: cond_true = ~w_c;
      COND_MI: cond_true = w_n;
      COND_PL: cond_true = ~w_n;
      COND_VS: cond_true = w_v;
      COND_VC: cond_true = ~w_v;
      COND_HI: cond_true = w_c & ~w_z;
      COND_LS: cond_true = ~w_c | w_z;
      COND_GE: cond_true = (w_n == w_v);
      COND_LT: cond_true = (w_n != w_v);
      COND_GT: cond_true = ~w_z & (w_n == w_v);
      COND_LE: cond_true = w_z | (w_n != w_v);
      COND_AL: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/decode_control.sv
// ID-stage instruction decoder with bubble mux, branch resolution and EX pipeline register.
// Define DECODE_KEYWORD_EN to drive the ASCII mnemonic on keyword; otherwise it is tied to 0.
module decode_control
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        R,
  input  logic [31:0] instruction,
  input  logic        nop_sel,
  input  logic [3:0]  flags,
  output logic [3:0]  ID_opcode,
  output logic [1:0]  ID_AM,
  output logic        ID_S_enable,
  output logic        ID_load_instr,
  output logic        ID_RF_enable,
  output logic        ID_Size_enable,
  output logic        ID_RW_enable,
  output logic        ID_Enable_signal,
  output logic        ID_BL_instr,
  output logic        ID_B_instr,
  output logic [3:0]  ID_Rd,
  output logic        Branch,
  output logic        BranchL,
  output logic [47:0] keyword,
  output logic [3:0]  EX_opcode,
  output logic [1:0]  EX_AM,
  output logic        EX_S_enable,
  output logic        EX_load_instr,
  output logic        EX_RF_enable,
  output logic        EX_Size_enable,
  output logic        EX_RW_enable,
  output logic        EX_Enable_signal,
  output logic        EX_BL_enable
);

  logic [2:0] w_cls;
  logic       w_is_nop, w_is_dp, w_is_ls, w_is_br;
  ctrl_t      w_dec, w_id;
  logic       w_cond_true;
  logic       w_unused;

  assign w_cls    = instruction[27:25];
  assign w_is_nop = (instruction == 32'h0);
  assign w_is_dp  = ((w_cls == 3'b000) && !instruction[4]) || (w_cls == 3'b001);
  assign w_is_ls  = (w_cls[2:1] == 2'b01);
  assign w_is_br  = (w_cls == 3'b101);
  assign w_unused = ^{instruction[19:16], instruction[11:5], instruction[3:0]};

  always_comb begin
    w_dec = '0;
    if (w_is_nop) begin
      w_dec = '0;
    end else if (w_is_dp) begin
      w_dec.opcode    = instruction[24:21];
      w_dec.s_enable  = instruction[20];
      w_dec.am        = w_cls[0] ? AM_DP_IMM : AM_DP_REG;
      // Compare/test ops only set flags
      w_dec.rf_enable = (instruction[24:23] != 2'b10);
    end else if (w_is_ls) begin
      w_dec.enable_signal = 1'b1;
      w_dec.am            = w_cls[0] ? AM_LS_REG : AM_LS_IMM;
      w_dec.opcode        = instruction[23] ? OP_ADD : OP_SUB;
      w_dec.size_enable   = instruction[22];
      w_dec.load_instr    = instruction[20];
      w_dec.rf_enable     = instruction[20];
      w_dec.rw_enable     = ~instruction[20];
    end else if (w_is_br) begin
      w_dec.b_instr  = ~instruction[24];
      w_dec.bl_instr = instruction[24];
    end
  end

  assign w_id = nop_sel ? ctrl_t'('0) : w_dec;

  cond_eval u_cond_eval (
    .cond_code (instruction[31:28]),
    .flags     (flags),
    .cond_true (w_cond_true)
  );

  assign Branch           = w_cond_true & (w_id.b_instr | w_id.bl_instr);
  assign BranchL          = w_cond_true & w_id.bl_instr;
  assign ID_opcode        = w_id.opcode;
  assign ID_AM            = w_id.am;
  assign ID_S_enable      = w_id.s_enable;
  assign ID_load_instr    = w_id.load_instr;
  // BranchL is already zero under a bubble, so the link write is suppressed too
  assign ID_RF_enable     = w_id.rf_enable | BranchL;
  assign ID_Size_enable   = w_id.size_enable;
  assign ID_RW_enable     = w_id.rw_enable;
  assign ID_Enable_signal = w_id.enable_signal;
  assign ID_BL_instr      = w_id.bl_instr;
  assign ID_B_instr       = w_id.b_instr;
  assign ID_Rd            = BranchL ? 4'd14 : instruction[15:12];

`ifdef DECODE_KEYWORD_EN
  always_comb begin
    keyword = "UNDEF ";
    if (w_is_nop) begin
      keyword = "NOP   ";
    end else if (w_is_dp) begin
      keyword = dp_mnemonic(instruction[24:21]);
    end else if (w_is_ls) begin
      case ({instruction[20], instruction[22]})
        2'b10:   keyword = "LDR   ";
        2'b11:   keyword = "LDRB  ";
        2'b00:   keyword = "STR   ";
        default: keyword = "STRB  ";
      endcase
    end else if (w_is_br) begin
      keyword = instruction[24] ? "BL    " : "B     ";
    end
  end
`else
  assign keyword = 48'h0;
`endif

  logic [3:0] r_ex_opcode;
  logic [1:0] r_ex_am;
  logic       r_ex_s, r_ex_load, r_ex_rf, r_ex_size, r_ex_rw, r_ex_en, r_ex_bl;

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      r_ex_opcode <= '0;
      r_ex_am     <= '0;
      r_ex_s      <= 1'b0;
      r_ex_load   <= 1'b0;
      r_ex_rf     <= 1'b0;
      r_ex_size   <= 1'b0;
      r_ex_rw     <= 1'b0;
      r_ex_en     <= 1'b0;
      r_ex_bl     <= 1'b0;
    end else begin
      r_ex_opcode <= ID_opcode;
      r_ex_am     <= ID_AM;
      r_ex_s      <= ID_S_enable;
      r_ex_load   <= ID_load_instr;
      r_ex_rf     <= ID_RF_enable;
      r_ex_size   <= ID_Size_enable;
      r_ex_rw     <= ID_RW_enable;
      r_ex_en     <= ID_Enable_signal;
      r_ex_bl     <= BranchL;
    end
  end

  assign EX_opcode        = r_ex_opcode;
  assign EX_AM            = r_ex_am;
  assign EX_S_enable      = r_ex_s;
  assign EX_load_instr    = r_ex_load;
  assign EX_RF_enable     = r_ex_rf;
  assign EX_Size_enable   = r_ex_size;
  assign EX_RW_enable     = r_ex_rw;
  assign EX_Enable_signal = r_ex_en;
  assign EX_BL_enable     = r_ex_bl;

endmodule

// File: tb/tb_decode_control.sv
// Self-checking bench for decode_control: hand-derived vectors, EX stage checked via a queue.
module tb_decode_control;

  logic        clk = 1'b0;
  logic        R;
  logic [31:0] instruction;
  logic        nop_sel;
  logic [3:0]  flags;
  logic [3:0]  ID_opcode, ID_Rd, EX_opcode;
  logic [1:0]  ID_AM, EX_AM;
  logic        ID_S_enable, ID_load_instr, ID_RF_enable, ID_Size_enable, ID_RW_enable;
  logic        ID_Enable_signal, ID_BL_instr, ID_B_instr, Branch, BranchL;
  logic [47:0] keyword;
  logic        EX_S_enable, EX_load_instr, EX_RF_enable, EX_Size_enable, EX_RW_enable;
  logic        EX_Enable_signal, EX_BL_enable;

  always #5 clk = ~clk;

  decode_control dut (
    .clk              (clk),
    .R                (R),
    .instruction      (instruction),
    .nop_sel          (nop_sel),
    .flags            (flags),
    .ID_opcode        (ID_opcode),
    .ID_AM            (ID_AM),
    .ID_S_enable      (ID_S_enable),
    .ID_load_instr    (ID_load_instr),
    .ID_RF_enable     (ID_RF_enable),
    .ID_Size_enable   (ID_Size_enable),
    .ID_RW_enable     (ID_RW_enable),
    .ID_Enable_signal (ID_Enable_signal),
    .ID_BL_instr      (ID_BL_instr),
    .ID_B_instr       (ID_B_instr),
    .ID_Rd            (ID_Rd),
    .Branch           (Branch),
    .BranchL          (BranchL),
    .keyword          (keyword),
    .EX_opcode        (EX_opcode),
    .EX_AM            (EX_AM),
    .EX_S_enable      (EX_S_enable),
    .EX_load_instr    (EX_load_instr),
    .EX_RF_enable     (EX_RF_enable),
    .EX_Size_enable   (EX_Size_enable),
    .EX_RW_enable     (EX_RW_enable),
    .EX_Enable_signal (EX_Enable_signal),
    .EX_BL_enable     (EX_BL_enable)
  );

  typedef struct {
    logic [31:0] instr;
    logic        nop;
    logic [3:0]  flg;
    logic [3:0]  opc;
    logic [1:0]  am;
    logic [7:0]  bits;  // {s, ld, rf, sz, rw, en, bl, b}
    logic        br;
    logic        brl;
    logic [3:0]  rd;
    logic [47:0] kw;
  } vec_t;

  vec_t        vecs[$];
  logic [14:0] ex_q[$];  // {opc, am, s, ld, rf, sz, rw, en, bl_enable}
  int          n_total = 0;
  int          n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic add(input logic [31:0] instr, input logic nop, input logic [3:0] flg,
                     input logic [3:0] opc, input logic [1:0] am, input logic [7:0] bits,
                     input logic br, input logic brl, input logic [3:0] rd,
                     input logic [47:0] kw);
    vec_t v;
    v.instr = instr; v.nop = nop; v.flg = flg; v.opc = opc; v.am = am; v.bits = bits;
    v.br = br; v.brl = brl; v.rd = rd;
`ifdef DECODE_KEYWORD_EN
    v.kw = kw;
`else
    v.kw = 48'h0;
`endif
    vecs.push_back(v);
  endtask

  function automatic logic [14:0] ex_obs();
    return {EX_opcode, EX_AM, EX_S_enable, EX_load_instr, EX_RF_enable, EX_Size_enable,
            EX_RW_enable, EX_Enable_signal, EX_BL_enable};
  endfunction

  task automatic apply(input vec_t v, input int idx);
    logic [13:0] id_got, id_exp;
    @(negedge clk);
    instruction = v.instr; nop_sel = v.nop; flags = v.flg;
    #1;
    id_got = {ID_opcode, ID_AM, ID_S_enable, ID_load_instr, ID_RF_enable, ID_Size_enable,
              ID_RW_enable, ID_Enable_signal, ID_BL_instr, ID_B_instr};
    id_exp = {v.opc, v.am, v.bits};
    check($sformatf("id_ctrl[%0d]", idx), 64'(id_got), 64'(id_exp));
    check($sformatf("branch[%0d]", idx), 64'({Branch, BranchL}), 64'({v.br, v.brl}));
    check($sformatf("rd[%0d]", idx), 64'(ID_Rd), 64'(v.rd));
    check($sformatf("keyword[%0d]", idx), 64'(keyword), 64'(v.kw));
    // EX_BL_enable takes BranchL, not ID_BL_instr
    ex_q.push_back({v.opc, v.am, v.bits[7:2], v.brl});
    @(posedge clk);
    #1;
    if (ex_q.size() == 0) check("ex_queue_empty", 64'd1, 64'd0);
    else check($sformatf("ex[%0d]", idx), 64'(ex_obs()), 64'(ex_q.pop_front()));
  endtask

  initial begin
    //   instr         nop flg   opc   am     s ld rf sz rw en bl b  br brl rd    kw
    add(32'hE2821005, 0, 4'h0, 4'h4, 2'b00, 8'b0_0_1_0_0_0_0_0, 0, 0, 4'd1, "ADD   ");
    add(32'hE0513002, 0, 4'h0, 4'h2, 2'b01, 8'b1_0_1_0_0_0_0_0, 0, 0, 4'd3, "SUB   ");
    add(32'hE5515004, 0, 4'h0, 4'h2, 2'b10, 8'b0_1_1_1_0_1_0_0, 0, 0, 4'd5, "LDRB  ");
    add(32'h0A000003, 0, 4'h4, 4'h0, 2'b00, 8'b0_0_0_0_0_0_0_1, 1, 0, 4'd0, "B     ");
    add(32'h0A000003, 0, 4'h0, 4'h0, 2'b00, 8'b0_0_0_0_0_0_0_1, 0, 0, 4'd0, "B     ");
    add(32'hEB000005, 0, 4'h0, 4'h0, 2'b00, 8'b0_0_1_0_0_0_1_0, 1, 1, 4'd14, "BL    ");
    add(32'hE2821005, 1, 4'h0, 4'h0, 2'b00, 8'b0_0_0_0_0_0_0_0, 0, 0, 4'd1, "ADD   ");
    add(32'h00000000, 0, 4'hF, 4'h0, 2'b00, 8'b0_0_0_0_0_0_0_0, 0, 0, 4'd0, "NOP   ");
    add(32'hE5812000, 0, 4'h0, 4'h4, 2'b10, 8'b0_0_0_0_1_1_0_0, 0, 0, 4'd2, "STR   ");
    add(32'hE7D43002, 0, 4'h0, 4'h4, 2'b11, 8'b0_1_1_1_0_1_0_0, 0, 0, 4'd3, "LDRB  ");
    add(32'hE1510002, 0, 4'h0, 4'hA, 2'b01, 8'b1_0_0_0_0_0_0_0, 0, 0, 4'd0, "CMP   ");
    add(32'hE8BD0000, 0, 4'h0, 4'h0, 2'b00, 8'b0_0_0_0_0_0_0_0, 0, 0, 4'd0, "UNDEF ");
    add(32'hE0010091, 0, 4'h0, 4'h0, 2'b00, 8'b0_0_0_0_0_0_0_0, 0, 0, 4'd0, "UNDEF ");
    add(32'hFA000000, 0, 4'hF, 4'h0, 2'b00, 8'b0_0_0_0_0_0_0_1, 0, 0, 4'd0, "B     ");
    add(32'hCA000000, 0, 4'h0, 4'h0, 2'b00, 8'b0_0_0_0_0_0_0_1, 1, 0, 4'd0, "B     ");
    add(32'hCA000000, 0, 4'h4, 4'h0, 2'b00, 8'b0_0_0_0_0_0_0_1, 0, 0, 4'd0, "B     ");
    add(32'hBA000000, 0, 4'h8, 4'h0, 2'b00, 8'b0_0_0_0_0_0_0_1, 1, 0, 4'd0, "B     ");
    add(32'hEB000005, 1, 4'h0, 4'h0, 2'b00, 8'b0_0_0_0_0_0_0_0, 0, 0, 4'd0, "BL    ");
    add(32'hE3B00001, 0, 4'h0, 4'hD, 2'b00, 8'b1_0_1_0_0_0_0_0, 0, 0, 4'd0, "MOV   ");
    add(32'h5A000000, 0, 4'h0, 4'h0, 2'b00, 8'b0_0_0_0_0_0_0_1, 1, 0, 4'd0, "B     ");

    R = 1'b1; instruction = 32'hE2821005; nop_sel = 1'b0; flags = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ex", 64'(ex_obs()), 64'd0);
    @(negedge clk);
    R = 1'b0;

    foreach (vecs[i]) apply(vecs[i], i);

    // Asynchronous reset mid-stream, between clock edges
    apply(vecs[0], 100);
    #2;
    R = 1'b1;
    #1;
    check("async_reset_ex", 64'(ex_obs()), 64'd0);
    @(posedge clk);
    #1;
    check("reset_held_ex", 64'(ex_obs()), 64'd0);
    check("reset_comb_id", 64'({ID_opcode, ID_RF_enable}), 64'({4'h4, 1'b1}));
    @(negedge clk);
    R = 1'b0;
    #1;
    check("release_no_edge_ex", 64'(ex_obs()), 64'd0);
    @(posedge clk);
    #1;
    check("release_first_edge_ex", 64'(ex_obs()), 64'({4'h4, 2'b00, 6'b001000, 1'b0}));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/decode_control.md
DECODE_CONTROL -- requirements
Module: decode_control

Interface
REQ-001 SHALL have no parameters; every instance is identical apart from the DECODE_KEYWORD_EN macro (REQ-026).
REQ-002 clk  in  1  single clock; all state rises on posedge.
REQ-003 R  in  1  reset; asynchronous, active-high.
REQ-004 instruction  in  32  IF/ID instruction word; bits [31:28] are the condition code.
REQ-005 nop_sel  in  1  stall/bubble select from the forwarding unit; 1 forces a bubble.
REQ-006 flags  in  4  {N,Z,C,V}, already selected between ALU and PSR.
REQ-007 ID_opcode out 4, ID_AM out 2, ID_S_enable, ID_load_instr, ID_RF_enable, ID_Size_enable, ID_RW_enable, ID_Enable_signal, ID_BL_instr, ID_B_instr out 1 each: post-bubble-mux ID-stage control signals.
REQ-008 ID_Rd  out  4  destination register: 14 when BranchL, else instruction[15:12].
REQ-009 Branch, BranchL  out  1 each  taken-branch and taken-link.
REQ-010 keyword  out  48  6-char ASCII mnemonic, space-padded, first character in [47:40].
REQ-011 EX_opcode, EX_AM, EX_S_enable, EX_load_instr, EX_RF_enable, EX_Size_enable, EX_RW_enable, EX_Enable_signal, EX_BL_enable  out  registered copies for the EX stage.

Function
REQ-012 Data processing ([27:25]=000 with bit4=0, or [27:25]=001): opcode=[24:21]; S_enable=[20]; AM=00 for immediate, 01 for register; RF_enable=1 except opcodes 1000-1011 (TST/TEQ/CMP/CMN), where it is 0.
REQ-013 Load/store ([27:25]=010/011): Enable_signal=1; AM=10 for immediate, 11 for register; opcode=0100 if U=[23]=1, else 0010; Size_enable=[22]; S_enable=0.
REQ-014 Load (L=[20]=1): load_instr=1, RF_enable=1, RW_enable=0. Store: load_instr=0, RF_enable=0, RW_enable=1 (1 = write).
REQ-015 Branch ([27:25]=101): B_instr=~[24]; BL_instr=[24]; all other controls 0.
REQ-016 Instruction 0x00000000 and any other encoding: all controls 0; keyword "NOP   " or "UNDEF " respectively.
REQ-017 Keyword strings: the 16 data-processing mnemonics (AND..MVN), "LDR"/"LDRB"/"STR"/"STRB", "B", "BL".
REQ-018 Bubble mux: nop_sel=1 drives every ID_* control to 0; nop_sel=0 passes the decode through. keyword is not muxed.
REQ-019 Condition evaluation follows the ARM table for codes 0000-1101; 1110 is always true; 1111 is never true.
REQ-020 Branch = cond_true & (ID_B_instr | ID_BL_instr); BranchL = cond_true & ID_BL_instr. Both use post-mux signals, so a stall suppresses branching.
REQ-021 ID_RF_enable = nop_sel ? 0 : (RF_enable | BranchL).
REQ-022 All ID_*, Branch, BranchL, ID_Rd and keyword outputs are purely combinational.
REQ-023 EX_* outputs load the ID_* values (EX_BL_enable <= BranchL) on every posedge clk, giving 1-cycle latency, with no hold.

Reset
REQ-024 While R=1, all EX_* outputs are 0 immediately, independent of clk; this includes reset asserted mid-stream.
REQ-025 Release of R is sampled at the next posedge; combinational outputs are unaffected by R.

Configuration
REQ-026 With DECODE_KEYWORD_EN defined, keyword follows REQ-010/017; without it, keyword is a constant 0 and the port remains present.

Structure
REQ-027 Package decode_pkg SHALL hold the ALU opcode constants, the AM encodings (00/01/10/11), the condition code constants and a packed control-bundle struct.
REQ-028 One sub-module, cond_eval (cond_code, flags -> cond_true), SHALL be used.

Verification
REQ-029 0xE2821005 (ADD R1,R2,#5), nop_sel=0 -> opcode 0100, AM 00, S 0, RF_enable 1, keyword "ADD   ", Branch 0.
REQ-030 0xE0513002 (SUBS R3,R1,R2) -> opcode 0010, AM 01, S 1, RF_enable 1; EX_* equal these values one clk later.
REQ-031 0xE5515004 (LDRB R5,[R1,#-4]) -> load 1, RF 1, Size 1, Enable 1, RW 0, opcode 0010, AM 10.
REQ-032 0x0A000003 (BEQ): flags 0100 -> Branch 1, BranchL 0; flags 0000 -> Branch 0.
REQ-033 0xEB000005 (BL) -> Branch 1, BranchL 1, ID_RF_enable 1, ID_Rd 14.
REQ-034 nop_sel=1 with 0xE2821005 -> all ID_* 0 and Branch 0; asserting R mid-run -> EX_* 0 with no clk edge.
